// File: rtl/axi4_bram_if.sv
// axi4_bram_if: AXI4 write/read channel bundle between an initiator and the BRAM responder
interface axi4_bram_if #(
    parameter int ID_W   = 1,
    parameter int ADDR_W = 24
);
    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [1:0]        awburst;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;
    logic [ID_W-1:0]   rid;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;
    modport slave (
        input  awid, awaddr, awlen, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
    modport master (
        output awid, awaddr, awlen, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface

// File: rtl/axi4_bram_responder.sv
// axi4_bram_responder: AXI4 subordinate serving INCR/FIXED bursts from on-chip block RAM
module axi4_bram_responder #(
    parameter int ID_W   = 1,
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4096
) (
    input logic        clk,
    input logic        rst,
    axi4_bram_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
    localparam logic [1:0] INCR = 2'b01, WRAP = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_RAM, R_DATA} r_state_t;

    // response codes are ordered so the numerically larger one is the worse one
    function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    w_state_t          ws;
    logic [ADDR_W-1:0] waddr;
    logic [7:0]        wcnt;
    logic [1:0]        wburst;
    logic [1:0]        werr;
    logic [ID_W-1:0]   wid;
    r_state_t          rs;
    logic [ADDR_W-1:0] raddr;
    logic [7:0]        rcnt;
    logic [1:0]        rburst;
    logic [ID_W-1:0]   rid_q;
    logic              rok;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] ram_q;

    logic       w_fire, w_oor, w_wrap, w_we, r_oor, r_wrap;
    logic [1:0] w_acc;

    assign w_fire = (ws == W_DATA) && bus.wvalid && bus.wready;
    assign w_oor  = |waddr[ADDR_W-1:AW+2];
    assign w_wrap = wburst == WRAP;
    assign w_we   = w_fire && !w_oor && !w_wrap;
    assign w_acc  = worst(worst(werr, w_wrap ? SLVERR : (w_oor ? DECERR : OKAY)),
                          (bus.wlast != (wcnt == 8'd0)) ? SLVERR : OKAY);
    assign r_oor  = |raddr[ADDR_W-1:AW+2];
    assign r_wrap = rburst == WRAP;
    // out-of-range and WRAP beats read as zero while the RAM word is still held for valid beats
    assign bus.rdata = rok ? ram_q : '0;

    // write channel: accept address, absorb beats, then hold the merged response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ws          <= W_IDLE;
            bus.awready <= 1'b0;
            bus.wready  <= 1'b0;
            bus.bvalid  <= 1'b0;
            bus.bresp   <= OKAY;
            bus.bid     <= '0;
            waddr       <= '0;
            wcnt        <= '0;
            wburst      <= '0;
            werr        <= OKAY;
            wid         <= '0;
        end else begin
            case (ws)
                W_IDLE: begin
                    bus.awready <= 1'b1;
                    if (bus.awvalid && bus.awready) begin
                        bus.awready <= 1'b0;
                        bus.wready  <= 1'b1;
                        wid         <= bus.awid;
                        waddr       <= bus.awaddr;
                        wcnt        <= bus.awlen;
                        wburst      <= bus.awburst;
                        werr        <= OKAY;
                        ws          <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        werr  <= w_acc;
                        waddr <= waddr + ((wburst == INCR) ? ADDR_W'(4) : '0);
                        if (wcnt == 8'd0) begin
                            bus.wready <= 1'b0;
                            bus.bvalid <= 1'b1;
                            bus.bresp  <= w_acc;
                            bus.bid    <= wid;
                            ws         <= W_RESP;
                        end else begin
                            wcnt <= wcnt - 8'd1;
                        end
                    end
                end
                W_RESP: begin
                    if (bus.bready) begin
                        bus.bvalid  <= 1'b0;
                        bus.awready <= 1'b1;
                        ws          <= W_IDLE;
                    end
                end
                default: ws <= W_IDLE;
            endcase
        end
    end

    // block RAM: byte-lane writes and a one-cycle registered read issued from R_RAM
    always_ff @(posedge clk) begin
        if (w_we)
            for (int i = 0; i < DATA_W / 8; i++)
                if (bus.wstrb[i]) mem[waddr[AW+1:2]][8*i +: 8] <= bus.wdata[8*i +: 8];
        if (rs == R_RAM) ram_q <= mem[raddr[AW+1:2]];
    end

    // read channel: one RAM access per beat, beat held until the initiator takes it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs          <= R_IDLE;
            bus.arready <= 1'b0;
            bus.rvalid  <= 1'b0;
            bus.rlast   <= 1'b0;
            bus.rresp   <= OKAY;
            bus.rid     <= '0;
            rok         <= 1'b0;
            raddr       <= '0;
            rcnt        <= '0;
            rburst      <= '0;
            rid_q       <= '0;
        end else begin
            case (rs)
                R_IDLE: begin
                    bus.arready <= 1'b1;
                    if (bus.arvalid && bus.arready) begin
                        bus.arready <= 1'b0;
                        rid_q       <= bus.arid;
                        raddr       <= bus.araddr;
                        rcnt        <= bus.arlen;
                        rburst      <= bus.arburst;
                        rs          <= R_RAM;
                    end
                end
                R_RAM: begin
                    bus.rvalid <= 1'b1;
                    bus.rid    <= rid_q;
                    bus.rlast  <= rcnt == 8'd0;
                    bus.rresp  <= r_wrap ? SLVERR : (r_oor ? DECERR : OKAY);
                    rok        <= !r_wrap && !r_oor;
                    rs         <= R_DATA;
                end
                R_DATA: begin
                    if (bus.rready) begin
                        bus.rvalid <= 1'b0;
                        bus.rlast  <= 1'b0;
                        rok        <= 1'b0;
                        if (bus.rlast) begin
                            bus.arready <= 1'b1;
                            rs          <= R_IDLE;
                        end else begin
                            raddr <= raddr + ((rburst == INCR) ? ADDR_W'(4) : '0);
                            rcnt  <= rcnt - 8'd1;
                            rs    <= R_RAM;
                        end
                    end
                end
                default: rs <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi4_bram_responder.sv
// tb_axi4_bram_responder: scoreboard bench for the AXI4 BRAM responder
module tb_axi4_bram_responder;
    localparam int ID_W = 1, ADDR_W = 24, DEPTH = 4096;
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

    typedef struct {logic [ID_W-1:0] id; logic [1:0] resp;} b_exp_t;
    typedef struct {logic [ID_W-1:0] id; logic [31:0] data; logic [1:0] resp; logic last;} r_exp_t;
    typedef logic [31:0] beats_t [4];

    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    b_exp_t bq[$];
    r_exp_t rq[$];

    always #5 clk = ~clk;

    axi4_bram_if #(.ID_W(ID_W), .ADDR_W(ADDR_W)) bus ();

    axi4_bram_responder #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(32), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // monitor: pop and compare whenever a B or R beat is handed over
    always @(negedge clk) begin
        if (!rst && bus.bvalid && bus.bready) begin
            if (bq.size() == 0) chk("b_unexpected", {63'd0, bus.bvalid}, 64'd0);
            else begin
                b_exp_t e;
                e = bq.pop_front();
                chk("bresp", bus.bresp, e.resp);
                chk("bid", bus.bid, e.id);
            end
        end
        if (!rst && bus.rvalid && bus.rready) begin
            if (rq.size() == 0) chk("r_unexpected", {63'd0, bus.rvalid}, 64'd0);
            else begin
                r_exp_t e;
                e = rq.pop_front();
                chk("rdata", bus.rdata, e.data);
                chk("rresp", bus.rresp, e.resp);
                chk("rlast", bus.rlast, e.last);
                chk("rid", bus.rid, e.id);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic aw_send(input logic [23:0] a, input logic [7:0] len, input logic [1:0] burst, input logic [ID_W-1:0] id);
        logic hs = 1'b0;
        bus.awaddr = a; bus.awlen = len; bus.awburst = burst; bus.awid = id; bus.awvalid = 1'b1;
        for (int n = 0; n < 50 && !hs; n++) begin @(negedge clk); hs = bus.awready; end
        if (!hs) chk("aw_timeout", {63'd0, bus.awready}, 64'd1);
        @(posedge clk); #1 bus.awvalid = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] d, input logic [3:0] strb, input logic last);
        logic hs = 1'b0;
        bus.wdata = d; bus.wstrb = strb; bus.wlast = last; bus.wvalid = 1'b1;
        for (int n = 0; n < 50 && !hs; n++) begin @(negedge clk); hs = bus.wready; end
        if (!hs) chk("w_timeout", {63'd0, bus.wready}, 64'd1);
        @(posedge clk); #1 bus.wvalid = 1'b0; bus.wlast = 1'b0;
    endtask

    task automatic ar_send(input logic [23:0] a, input logic [7:0] len, input logic [1:0] burst, input logic [ID_W-1:0] id);
        logic hs = 1'b0;
        bus.araddr = a; bus.arlen = len; bus.arburst = burst; bus.arid = id; bus.arvalid = 1'b1;
        for (int n = 0; n < 50 && !hs; n++) begin @(negedge clk); hs = bus.arready; end
        if (!hs) chk("ar_timeout", {63'd0, bus.arready}, 64'd1);
        @(posedge clk); #1 bus.arvalid = 1'b0;
    endtask

    task automatic do_write(input logic [23:0] a, input logic [7:0] len, input logic [1:0] burst,
                            input logic [ID_W-1:0] id, input beats_t d, input logic [3:0] strb,
                            input bit drop_last, input logic [1:0] resp);
        bq.push_back('{id, resp});
        aw_send(a, len, burst, id);
        for (int i = 0; i <= int'(len); i++) w_send(d[i], strb, (i == int'(len)) && !drop_last);
        chk("bvalid_after_last_w", {63'd0, bus.bvalid}, 64'd1);
    endtask

    task automatic do_read(input logic [23:0] a, input logic [7:0] len, input logic [1:0] burst,
                           input logic [ID_W-1:0] id, input beats_t d, input logic [1:0] resp);
        for (int i = 0; i <= int'(len); i++) rq.push_back('{id, d[i], resp, i == int'(len)});
        ar_send(a, len, burst, id);
    endtask

    task automatic wait_b();
        for (int n = 0; n < 50 && bq.size() != 0; n++) @(negedge clk);
        if (bq.size() != 0) begin chk("b_timeout", bq.size(), 64'd0); bq.delete(); end
        @(posedge clk); #1;
    endtask

    task automatic wait_r();
        for (int n = 0; n < 100 && rq.size() != 0; n++) @(negedge clk);
        if (rq.size() != 0) begin chk("r_timeout", rq.size(), 64'd0); rq.delete(); end
        @(posedge clk); #1;
    endtask

    initial begin
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awburst = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b1;
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arburst = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {bus.awready, bus.wready, bus.arready}, 64'd0);
        chk("rst_valid", {bus.bvalid, bus.rvalid, bus.rlast}, 64'd0);
        chk("rst_payload", {bus.rdata, bus.bresp, bus.rresp, bus.bid, bus.rid}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("awready_after_rst", {63'd0, bus.awready}, 64'd1);
        chk("arready_after_rst", {63'd0, bus.arready}, 64'd1);

        // T1 single write and read-back
        do_write(24'h000004, 8'd0, INCR, 1'b0, '{32'hDEADBEEF, 32'h0, 32'h0, 32'h0}, 4'hF, 1'b0, OKAY);
        wait_b();
        do_read(24'h000004, 8'd0, INCR, 1'b1, '{32'hDEADBEEF, 32'h0, 32'h0, 32'h0}, OKAY);
        wait_r();

        // T2 byte strobes
        do_write(24'h000020, 8'd0, INCR, 1'b1, '{32'h11223344, 32'h0, 32'h0, 32'h0}, 4'hF, 1'b0, OKAY);
        wait_b();
        do_write(24'h000020, 8'd0, INCR, 1'b0, '{32'hAABBCCDD, 32'h0, 32'h0, 32'h0}, 4'b0101, 1'b0, OKAY);
        wait_b();
        do_read(24'h000020, 8'd0, INCR, 1'b0, '{32'h11BB33DD, 32'h0, 32'h0, 32'h0}, OKAY);
        wait_r();

        // T3 INCR write burst, FIXED and INCR read bursts
        do_write(24'h000010, 8'd3, INCR, 1'b1, '{32'd1, 32'd2, 32'd3, 32'd4}, 4'hF, 1'b0, OKAY);
        wait_b();
        do_read(24'h000010, 8'd3, FIXED, 1'b1, '{32'd1, 32'd1, 32'd1, 32'd1}, OKAY);
        wait_r();
        do_read(24'h000010, 8'd3, INCR, 1'b0, '{32'd1, 32'd2, 32'd3, 32'd4}, OKAY);
        wait_r();

        // T4 backpressure on B and R
        bus.bready = 1'b0;
        do_write(24'h000030, 8'd0, INCR, 1'b1, '{32'h55AA55AA, 32'h0, 32'h0, 32'h0}, 4'hF, 1'b0, OKAY);
        repeat (3) begin
            @(negedge clk);
            chk("b_hold_valid", {63'd0, bus.bvalid}, 64'd1);
            chk("b_hold_payload", {bus.bresp, bus.bid}, {2'b00, 1'b1});
        end
        @(posedge clk); #1 bus.bready = 1'b1;
        wait_b();
        bus.rready = 1'b0;
        do_read(24'h000010, 8'd1, INCR, 1'b1, '{32'd1, 32'd2, 32'd0, 32'd0}, OKAY);
        for (int n = 0; n < 20 && !bus.rvalid; n++) @(negedge clk);
        chk("r_bp_valid_seen", {63'd0, bus.rvalid}, 64'd1);
        repeat (5) begin
            @(negedge clk);
            chk("r_hold_valid", {63'd0, bus.rvalid}, 64'd1);
            chk("r_hold_payload", {bus.rdata, bus.rresp, bus.rlast, bus.rid}, {32'd1, 2'b00, 1'b0, 1'b1});
        end
        @(posedge clk); #1 bus.rready = 1'b1;
        wait_r();
        do_read(24'h000030, 8'd0, INCR, 1'b0, '{32'h55AA55AA, 32'h0, 32'h0, 32'h0}, OKAY);
        wait_r();

        // T5 error responses
        do_write(24'h000000, 8'd0, INCR, 1'b0, '{32'h0BADF00D, 32'h0, 32'h0, 32'h0}, 4'hF, 1'b0, OKAY);
        wait_b();
        do_write(24'(DEPTH * 4), 8'd0, INCR, 1'b1, '{32'hFFFFFFFF, 32'h0, 32'h0, 32'h0}, 4'hF, 1'b0, DECERR);
        wait_b();
        do_read(24'h000000, 8'd0, INCR, 1'b0, '{32'h0BADF00D, 32'h0, 32'h0, 32'h0}, OKAY);
        wait_r();
        do_read(24'(DEPTH * 4), 8'd0, INCR, 1'b1, '{32'h0, 32'h0, 32'h0, 32'h0}, DECERR);
        wait_r();
        do_read(24'h000010, 8'd1, WRAP, 1'b1, '{32'h0, 32'h0, 32'h0, 32'h0}, SLVERR);
        wait_r();
        do_write(24'h000040, 8'd1, INCR, 1'b0, '{32'hA1A1A1A1, 32'hB2B2B2B2, 32'h0, 32'h0}, 4'hF, 1'b1, SLVERR);
        wait_b();
        do_read(24'h000040, 8'd1, INCR, 1'b0, '{32'hA1A1A1A1, 32'hB2B2B2B2, 32'h0, 32'h0}, OKAY);
        wait_r();

        // T6 reset in the middle of a write burst
        do_write(24'h000050, 8'd3, INCR, 1'b0, '{32'h0, 32'h0, 32'h0, 32'h0}, 4'hF, 1'b0, OKAY);
        wait_b();
        aw_send(24'h000050, 8'd3, INCR, 1'b1);
        w_send(32'hC1C1C1C1, 4'hF, 1'b0);
        bus.wdata = 32'hC2C2C2C2; bus.wvalid = 1'b1; rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", {bus.awready, bus.wready, bus.arready}, 64'd0);
        chk("mid_rst_valid", {bus.bvalid, bus.rvalid, bus.rlast}, 64'd0);
        chk("mid_rst_payload", {bus.rdata, bus.bresp, bus.rresp, bus.bid, bus.rid}, 64'd0);
        @(posedge clk); #1 bus.wvalid = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        chk("awready_after_mid_rst", {63'd0, bus.awready}, 64'd1);
        do_read(24'h000050, 8'd3, INCR, 1'b0, '{32'hC1C1C1C1, 32'h0, 32'h0, 32'h0}, OKAY);
        wait_r();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
